// File: rtl/dehaze_recover.sv
// rtl/dehaze_recover.sv - scene radiance recovery J = (I - A)/t + A, 4-stage pipeline
module dehaze_recover #(
  parameter logic [7:0] T_MIN  = 8'd26,
  parameter logic       VS_POL = 1'b1
) (
  input  logic       pixelclk,
  input  logic       reset_n,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  input  logic [7:0] i_trans,
  input  logic [7:0] i_atmos,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_de,
  input  logic       i_bypass,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de,
  output logic [7:0] o_atmos
);

  // Reciprocal table floor(65280/t) in Q8.8; each entry is an elaboration-time constant.
  logic [15:0] rom [256];
  for (genvar k = 0; k < 256; k++) begin : g_rom
    assign rom[k] = (k == 0) ? 16'd0 : 16'(65280 / ((k == 0) ? 1 : k));
  end

  // Frame-latched atmospheric light and vsync edge history
  logic       vs_q, vs_d;
  logic [7:0] a_q, a_d;

  // Pipeline state: colour index 0 = R, 1 = G, 2 = B
  logic [7:0]        c1_q [3], c1_d [3];
  logic [7:0]        c2_q [3], c2_d [3];
  logic [7:0]        c3_q [3], c3_d [3];
  logic [7:0]        rgb4_q [3], rgb4_d [3];
  logic [8:0]        d2_q [3], d2_d [3];
  logic signed [25:0] p3_q [3], p3_d [3];
  logic [7:0]        t1_q, t1_d;
  logic [15:0]       recip2_q, recip2_d;
  logic [7:0]        a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic [3:0]        de_sr_q, de_sr_d, hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;
  logic [2:0]        byp_sr_q, byp_sr_d;

  logic signed [25:0] op_d, op_r, s_val;

  // Next-state for the A latch and all four pipeline stages
  always_comb begin
    vs_d     = i_vsync;
    a_d      = ((i_vsync == VS_POL) && (vs_q != VS_POL)) ? i_atmos : a_q;
    t1_d     = (i_trans < T_MIN) ? T_MIN : i_trans;
    a1_d     = a_q;
    recip2_d = rom[t1_q];
    a2_d     = a1_q;
    a3_d     = a2_q;
    de_sr_d  = {de_sr_q[2:0], i_de};
    hs_sr_d  = {hs_sr_q[2:0], i_hsync};
    vs_sr_d  = {vs_sr_q[2:0], i_vsync};
    byp_sr_d = {byp_sr_q[1:0], i_bypass};
    c1_d     = '{i_r, i_g, i_b};
    c2_d     = c1_q;
    c3_d     = c2_q;
    d2_d     = '{default: '0};
    p3_d     = '{default: '0};
    rgb4_d   = '{default: '0};
    op_d     = '0;
    op_r     = '0;
    s_val    = '0;
    for (int i = 0; i < 3; i++) begin
      // Difference to A as a 9-bit two's complement value
      d2_d[i] = {1'b0, c1_q[i]} - {1'b0, a1_q};
      // Signed difference times unsigned Q8.8 reciprocal; the true product fits 26 bits
      op_d    = {{17{d2_q[i][8]}}, d2_q[i]};
      op_r    = {10'b0, recip2_q};
      p3_d[i] = op_d * op_r;
      // Drop the fraction rounding toward -inf, restore A, then clip to 8 bits
      s_val   = (p3_q[i] >>> 8) + $signed({18'b0, a3_q});
      if (!de_sr_q[2]) begin
        rgb4_d[i] = 8'd0;
      end else if (byp_sr_q[2]) begin
        rgb4_d[i] = c3_q[i];
      end else if (s_val < 0) begin
        rgb4_d[i] = 8'd0;
      end else if (s_val > 26'sd255) begin
        rgb4_d[i] = 8'd255;
      end else begin
        rgb4_d[i] = s_val[7:0];
      end
    end
  end

  // State registers with synchronous active-low clear
  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      vs_q     <= 1'b0;
      a_q      <= '0;
      t1_q     <= '0;
      recip2_q <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
      a3_q     <= '0;
      de_sr_q  <= '0;
      hs_sr_q  <= '0;
      vs_sr_q  <= '0;
      byp_sr_q <= '0;
      c1_q     <= '{default: '0};
      c2_q     <= '{default: '0};
      c3_q     <= '{default: '0};
      d2_q     <= '{default: '0};
      p3_q     <= '{default: '0};
      rgb4_q   <= '{default: '0};
    end else begin
      vs_q     <= vs_d;
      a_q      <= a_d;
      t1_q     <= t1_d;
      recip2_q <= recip2_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      a3_q     <= a3_d;
      de_sr_q  <= de_sr_d;
      hs_sr_q  <= hs_sr_d;
      vs_sr_q  <= vs_sr_d;
      byp_sr_q <= byp_sr_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      c3_q     <= c3_d;
      d2_q     <= d2_d;
      p3_q     <= p3_d;
      rgb4_q   <= rgb4_d;
    end
  end

  assign o_r     = rgb4_q[0];
  assign o_g     = rgb4_q[1];
  assign o_b     = rgb4_q[2];
  assign o_de    = de_sr_q[3];
  assign o_hsync = hs_sr_q[3];
  assign o_vsync = vs_sr_q[3];
  assign o_atmos = a_q;

endmodule

// File: tb/tb_dehaze_recover.sv
// tb/tb_dehaze_recover.sv - directed self-checking bench for dehaze_recover
module tb_dehaze_recover;

  logic       pixelclk = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] i_r = '0, i_g = '0, i_b = '0, i_trans = '0, i_atmos = '0;
  logic       i_hsync = 1'b0, i_vsync = 1'b0, i_de = 1'b0, i_bypass = 1'b0;
  logic [7:0] o_r, o_g, o_b, o_atmos;
  logic       o_hsync, o_vsync, o_de;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0]  hv [0:39];
  logic [23:0] rv [0:39];

  always #5 pixelclk = ~pixelclk;

  dehaze_recover dut (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .i_r      (i_r),
    .i_g      (i_g),
    .i_b      (i_b),
    .i_trans  (i_trans),
    .i_atmos  (i_atmos),
    .i_hsync  (i_hsync),
    .i_vsync  (i_vsync),
    .i_de     (i_de),
    .i_bypass (i_bypass),
    .o_r      (o_r),
    .o_g      (o_g),
    .o_b      (o_b),
    .o_hsync  (o_hsync),
    .o_vsync  (o_vsync),
    .o_de     (o_de),
    .o_atmos  (o_atmos)
  );

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic vs_pulse(input logic [7:0] a);
    i_atmos = a;
    i_vsync = 1'b1;
    i_de    = 1'b0;
    tick();
    chk("atmos_latch", {24'b0, o_atmos}, {24'b0, a});
    i_vsync = 1'b0;
    tick();
  endtask

  task automatic pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [7:0] t);
    i_r = r; i_g = g; i_b = b; i_trans = t; i_de = 1'b1;
    tick();
    i_r = '0; i_g = '0; i_b = '0; i_de = 1'b0;
    tick();
    tick();
    chk("latency_early", {31'b0, o_de}, 32'd0);
    tick();
  endtask

  task automatic check_rgb(input string tag, input logic [7:0] er, input logic [7:0] eg,
                           input logic [7:0] eb);
    chk({tag, "_de"}, {31'b0, o_de}, 32'd1);
    chk({tag, "_r"}, {24'b0, o_r}, {24'b0, er});
    chk({tag, "_g"}, {24'b0, o_g}, {24'b0, eg});
    chk({tag, "_b"}, {24'b0, o_b}, {24'b0, eb});
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    tick(); tick(); tick();
    chk("rst_r", {24'b0, o_r}, 32'd0);
    chk("rst_g", {24'b0, o_g}, 32'd0);
    chk("rst_b", {24'b0, o_b}, 32'd0);
    chk("rst_de", {31'b0, o_de}, 32'd0);
    chk("rst_hs", {31'b0, o_hsync}, 32'd0);
    chk("rst_vs", {31'b0, o_vsync}, 32'd0);
    chk("rst_atmos", {24'b0, o_atmos}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Identity at t=255
    vs_pulse(8'd200);
    pixel(8'd100, 8'd150, 8'd250, 8'd255);
    check_rgb("identity", 8'd100, 8'd150, 8'd250);

    // Arithmetic and saturation, recip=510
    pixel(8'd100, 8'd180, 8'd250, 8'd128);
    check_rgb("arith", 8'd0, 8'd160, 8'd255);

    // Clamp of t below T_MIN, and t=0
    pixel(8'd201, 8'd210, 8'd200, 8'd5);
    check_rgb("clamp5", 8'd209, 8'd255, 8'd200);
    pixel(8'd201, 8'd210, 8'd200, 8'd0);
    check_rgb("clamp0", 8'd209, 8'd255, 8'd200);

    // A latch per frame
    vs_pulse(8'd180);
    pixel(8'd200, 8'd200, 8'd200, 8'd128);
    check_rgb("alatch1", 8'd219, 8'd219, 8'd219);
    i_atmos = 8'd220;
    tick();
    chk("atmos_hold", {24'b0, o_atmos}, 32'd180);
    pixel(8'd200, 8'd200, 8'd200, 8'd128);
    check_rgb("alatch_mid", 8'd219, 8'd219, 8'd219);
    vs_pulse(8'd220);
    pixel(8'd200, 8'd200, 8'd200, 8'd128);
    check_rgb("alatch2", 8'd180, 8'd180, 8'd180);

    // A=0 boundary: J = I*255/t saturated
    vs_pulse(8'd0);
    pixel(8'd100, 8'd200, 8'd0, 8'd128);
    check_rgb("a_zero", 8'd199, 8'd255, 8'd0);

    // Random sync pattern in bypass: exact 4-cycle delay and rgb gated by de
    vs_pulse(8'd200);
    i_bypass = 1'b1;
    for (int k = 0; k < 40; k++) begin
      hv[k] = 3'($urandom);
      rv[k] = 24'($urandom);
      i_de = hv[k][0]; i_hsync = hv[k][1]; i_vsync = hv[k][2];
      i_r = rv[k][7:0]; i_g = rv[k][15:8]; i_b = rv[k][23:16]; i_trans = 8'd128;
      tick();
      if (k >= 3) begin
        chk("rnd_de", {31'b0, o_de}, {31'b0, hv[k-3][0]});
        chk("rnd_hs", {31'b0, o_hsync}, {31'b0, hv[k-3][1]});
        chk("rnd_vs", {31'b0, o_vsync}, {31'b0, hv[k-3][2]});
        chk("rnd_rgb", {8'b0, o_b, o_g, o_r}, hv[k-3][0] ? {8'b0, rv[k-3]} : 32'd0);
      end
    end
    i_de = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0; i_bypass = 1'b0;
    i_r = '0; i_g = '0; i_b = '0;
    tick(); tick(); tick(); tick();

    // Reset mid-frame
    vs_pulse(8'd200);
    i_r = 8'd100; i_g = 8'd180; i_b = 8'd250; i_trans = 8'd128;
    i_de = 1'b1; i_hsync = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chk("pre_rst_de", {31'b0, o_de}, 32'd1);
    chk("pre_rst_hs", {31'b0, o_hsync}, 32'd1);
    chk("pre_rst_g", {24'b0, o_g}, 32'd160);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_r", {24'b0, o_r}, 32'd0);
    chk("mid_rst_g", {24'b0, o_g}, 32'd0);
    chk("mid_rst_b", {24'b0, o_b}, 32'd0);
    chk("mid_rst_de", {31'b0, o_de}, 32'd0);
    chk("mid_rst_hs", {31'b0, o_hsync}, 32'd0);
    chk("mid_rst_atmos", {24'b0, o_atmos}, 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_de", {31'b0, o_de}, 32'd0);
      chk("post_rst_hs", {31'b0, o_hsync}, 32'd0);
      chk("post_rst_atmos", {24'b0, o_atmos}, 32'd0);
    end
    tick();
    chk("post_rst_a0_r", {24'b0, o_r}, 32'd199);
    chk("post_rst_a0_de", {31'b0, o_de}, 32'd1);
    i_de = 1'b0; i_hsync = 1'b0;
    tick(); tick(); tick(); tick();
    vs_pulse(8'd200);
    pixel(8'd100, 8'd180, 8'd250, 8'd128);
    check_rgb("recover", 8'd0, 8'd160, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
